// File: rtl/mask_coord_gen.sv
// Raster coordinate generator for center_of_mass: thresholds a pixel stream and emits
// (x, y) for every in-band pixel, plus one end-of-frame tabulate pulse with frame stats.
module mask_coord_gen #(
   parameter int unsigned  HRES        = 320,
   parameter int unsigned  VRES        = 180,
   parameter int unsigned  PIXEL_WIDTH = 8,
   localparam int unsigned HWIDTH      = $clog2(HRES),
   localparam int unsigned VWIDTH      = $clog2(VRES),
   localparam int unsigned CWIDTH      = HWIDTH + VWIDTH
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic [PIXEL_WIDTH-1:0] pixel_in,
   input  logic                   pixel_valid_in,
   input  logic                   frame_start_in,
   input  logic [PIXEL_WIDTH-1:0] lower_bound_in,
   input  logic [PIXEL_WIDTH-1:0] upper_bound_in,
   output logic [HWIDTH-1:0]      x_out,
   output logic [VWIDTH-1:0]      y_out,
   output logic                   valid_out,
   output logic                   tabulate_out,
   output logic [CWIDTH-1:0]      mask_count_out,
   output logic                   empty_out,
   output logic                   short_frame_out
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_CLOSE  = 2'd2;

   localparam logic [HWIDTH-1:0] XMAX = HWIDTH'(HRES - 1);
   localparam logic [VWIDTH-1:0] YMAX = VWIDTH'(VRES - 1);
   localparam logic [CWIDTH-1:0] CMAX = '1;

   // Reset asserts asynchronously and releases on a clock edge.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   logic [1:0]        r_state;
   logic [HWIDTH-1:0] r_x;
   logic [VWIDTH-1:0] r_y;
   logic [CWIDTH-1:0] r_cnt;
   logic              r_sof_pend;
   logic [HWIDTH-1:0] r_x_out;
   logic [VWIDTH-1:0] r_y_out;
   logic              r_valid;
   logic              r_tab;
   logic [CWIDTH-1:0] r_mask_count;
   logic              r_empty;
   logic              r_short;

   logic w_in_band;
   logic w_accept;
   logic w_last;
   logic w_sof_go;
   logic w_mid_sof;
   logic w_close;

   // An inverted band (lower > upper) fails one of the two compares for every pixel.
   assign w_in_band = (pixel_in >= lower_bound_in) && (pixel_in <= upper_bound_in);
   assign w_accept  = (r_state == ST_ACTIVE) && pixel_valid_in && !frame_start_in;
   assign w_last    = w_accept && (r_x == XMAX) && (r_y == YMAX);
   assign w_sof_go  = (r_state == ST_IDLE) && (frame_start_in || r_sof_pend);
   assign w_mid_sof = (r_state == ST_ACTIVE) && frame_start_in;
   assign w_close   = w_mid_sof || (r_state == ST_CLOSE);

   always_ff @(posedge clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state      <= ST_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_cnt        <= '0;
         r_sof_pend   <= 1'b0;
         r_x_out      <= '0;
         r_y_out      <= '0;
         r_valid      <= 1'b0;
         r_tab        <= 1'b0;
         r_mask_count <= '0;
         r_empty      <= 1'b0;
         r_short      <= 1'b0;
      end else begin
         r_valid    <= w_accept && w_in_band;
         r_tab      <= w_close;
         r_sof_pend <= (r_state == ST_CLOSE) && frame_start_in;

         if (w_accept && w_in_band) begin
            r_x_out <= r_x;
            r_y_out <= r_y;
         end

         if (w_close) begin
            r_mask_count <= r_cnt;
            r_empty      <= (r_cnt == '0);
            r_short      <= w_mid_sof;
         end

         if (w_sof_go || w_mid_sof) begin
            r_x   <= '0;
            r_y   <= '0;
            r_cnt <= '0;
         end else if (w_accept) begin
            if (r_x == XMAX) begin
               r_x <= '0;
               r_y <= (r_y == YMAX) ? '0 : r_y + 1'b1;
            end else begin
               r_x <= r_x + 1'b1;
            end
            if (w_in_band && (r_cnt != CMAX)) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         case (r_state)
            ST_IDLE:   if (w_sof_go) r_state <= ST_ACTIVE;
            ST_ACTIVE: if (w_last) r_state <= ST_CLOSE;
            ST_CLOSE:  r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   assign x_out           = r_x_out;
   assign y_out           = r_y_out;
   assign valid_out       = r_valid;
   assign tabulate_out    = r_tab;
   assign mask_count_out  = r_mask_count;
   assign empty_out       = r_empty;
   assign short_frame_out = r_short;

endmodule

// File: tb/tb_mask_coord_gen.sv
// Directed bench for mask_coord_gen on a 4x2 frame: vector table plus hand-written
// sequences for gapped streams, start-of-frame during close and mid-frame reset.
module tb_mask_coord_gen;

   localparam int unsigned HRES = 4;
   localparam int unsigned VRES = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pixel = '0;
   logic       pv = 1'b0;
   logic       sof = 1'b0;
   logic [7:0] lo = 8'd100;
   logic [7:0] hi = 8'd200;
   logic [1:0] x_o;
   logic [0:0] y_o;
   logic       valid_o;
   logic       tab_o;
   logic [2:0] cnt_o;
   logic       empty_o;
   logic       short_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mask_coord_gen #(
      .HRES        (HRES),
      .VRES        (VRES),
      .PIXEL_WIDTH (8)
   ) u_dut (
      .clk_in          (clk),
      .rst_n_in        (rst_n),
      .pixel_in        (pixel),
      .pixel_valid_in  (pv),
      .frame_start_in  (sof),
      .lower_bound_in  (lo),
      .upper_bound_in  (hi),
      .x_out           (x_o),
      .y_out           (y_o),
      .valid_out       (valid_o),
      .tabulate_out    (tab_o),
      .mask_count_out  (cnt_o),
      .empty_out       (empty_o),
      .short_frame_out (short_o)
   );

   typedef struct {
      logic       sof;
      logic       pv;
      logic [7:0] pix;
      logic [7:0] lo;
      logic [7:0] hi;
      logic       ev;
      logic [1:0] ex;
      logic [0:0] ey;
      logic       et;
      logic [2:0] ec;
      logic       ee;
      logic       es;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic s, input logic p, input logic [7:0] px,
                               input logic [7:0] l, input logic [7:0] h, input logic ev,
                               input logic [1:0] ex, input logic [0:0] ey, input logic et,
                               input logic [2:0] ec, input logic ee, input logic es);
      vec_t v;
      v.sof = s; v.pv = p; v.pix = px; v.lo = l; v.hi = h;
      v.ev = ev; v.ex = ex; v.ey = ey; v.et = et; v.ec = ec; v.ee = ee; v.es = es;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the edge that consumed them.
   task automatic step(input logic s, input logic p, input logic [7:0] px);
      sof   = s;
      pv    = p;
      pixel = px;
      @(posedge clk);
      #1;
      sof   = 1'b0;
      pv    = 1'b0;
   endtask

   task automatic chk_pix(input string name, input logic [1:0] ex, input logic [0:0] ey);
      chk({name, " valid"}, valid_o, 1);
      chk({name, " x"}, x_o, ex);
      chk({name, " y"}, y_o, ey);
      chk({name, " tab"}, tab_o, 0);
   endtask

   initial begin
      logic [7:0] bad_band [8];
      bad_band = '{8'd100, 8'd150, 8'd200, 8'd150, 8'd100, 8'd150, 8'd200, 8'd0};

      // frame 1: bounds [100,200], pixels 50,100,150,250,200,0,199,201
      add(1, 0, 0,   100, 200, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 50,  100, 200, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 100, 100, 200, 1, 1, 0, 0, 0, 0, 0);
      add(0, 1, 150, 100, 200, 1, 2, 0, 0, 0, 0, 0);
      add(0, 1, 250, 100, 200, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 200, 100, 200, 1, 0, 1, 0, 0, 0, 0);
      add(0, 1, 0,   100, 200, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 199, 100, 200, 1, 2, 1, 0, 0, 0, 0);
      add(0, 1, 201, 100, 200, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0,   100, 200, 0, 0, 0, 1, 4, 0, 0);
      add(0, 0, 0,   100, 200, 0, 0, 0, 0, 4, 0, 0);
      // frame 2: inverted band, nothing in band
      add(1, 0, 0,   200, 100, 0, 0, 0, 0, 4, 0, 0);
      for (int i = 0; i < 8; i++) add(0, 1, bad_band[i], 200, 100, 0, 0, 0, 0, 4, 0, 0);
      add(0, 0, 0,   200, 100, 0, 0, 0, 1, 0, 1, 0);
      // frame 3: short after 3 in-band pixels, then sof coincident with a pixel
      add(0, 0, 0,   100, 200, 0, 0, 0, 0, 0, 1, 0);
      add(1, 0, 0,   100, 200, 0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 120, 100, 200, 1, 0, 0, 0, 0, 1, 0);
      add(0, 1, 130, 100, 200, 1, 1, 0, 0, 0, 1, 0);
      add(0, 1, 140, 100, 200, 1, 2, 0, 0, 0, 1, 0);
      add(1, 0, 0,   100, 200, 0, 0, 0, 1, 3, 0, 1);
      add(0, 1, 110, 100, 200, 1, 0, 0, 0, 3, 0, 1);
      add(1, 1, 150, 100, 200, 0, 0, 0, 1, 1, 0, 1);
      add(0, 1, 160, 100, 200, 1, 0, 0, 0, 1, 0, 1);
      add(0, 1, 170, 100, 200, 1, 1, 0, 0, 1, 0, 1);

      #1;
      chk("reset valid", valid_o, 0);
      chk("reset tab", tab_o, 0);
      chk("reset x", x_o, 0);
      chk("reset y", y_o, 0);
      chk("reset cnt", cnt_o, 0);
      chk("reset empty", empty_o, 0);
      chk("reset short", short_o, 0);
      #11 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      foreach (vq[i]) begin
         lo = vq[i].lo;
         hi = vq[i].hi;
         step(vq[i].sof, vq[i].pv, vq[i].pix);
         chk($sformatf("vec%0d valid", i), valid_o, vq[i].ev);
         chk($sformatf("vec%0d tab", i), tab_o, vq[i].et);
         chk($sformatf("vec%0d cnt", i), cnt_o, vq[i].ec);
         chk($sformatf("vec%0d empty", i), empty_o, vq[i].ee);
         chk($sformatf("vec%0d short", i), short_o, vq[i].es);
         if (vq[i].ev) begin
            chk($sformatf("vec%0d x", i), x_o, vq[i].ex);
            chk($sformatf("vec%0d y", i), y_o, vq[i].ey);
         end
      end

      // Gapped full frame, all in band: count of 8 saturates at 7.
      lo = 8'd100;
      hi = 8'd200;
      step(1, 0, 0);
      chk("gap sof tab", tab_o, 1);
      chk("gap sof short", short_o, 1);
      chk("gap sof cnt", cnt_o, 2);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 8'd150);
         chk_pix($sformatf("gap%0d", i), 2'(i % 4), 1'(i / 4));
         if (i < 7) begin
            for (int k = 0; k < 2; k++) begin
               step(0, 0, 0);
               chk($sformatf("gap%0d idle valid", i), valid_o, 0);
               chk($sformatf("gap%0d idle tab", i), tab_o, 0);
            end
         end
      end
      step(0, 0, 0);
      chk("gap end tab", tab_o, 1);
      chk("gap end valid", valid_o, 0);
      chk("gap end cnt", cnt_o, 7);
      chk("gap end empty", empty_o, 0);
      chk("gap end short", short_o, 0);
      step(0, 0, 0);
      chk("gap end tab clear", tab_o, 0);

      // Back-to-back frame with sof arriving during the close cycle.
      step(1, 0, 0);
      chk("b2b sof tab", tab_o, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 8'd150);
         chk_pix($sformatf("b2b%0d", i), 2'(i % 4), 1'(i / 4));
      end
      step(1, 0, 0);
      chk("close sof tab", tab_o, 1);
      chk("close sof valid", valid_o, 0);
      chk("close sof cnt", cnt_o, 7);
      chk("close sof short", short_o, 0);
      step(0, 1, 8'd150);
      chk("pend idle valid", valid_o, 0);
      chk("pend idle tab", tab_o, 0);
      step(0, 1, 8'd150);
      chk_pix("pend first", 2'd0, 1'd0);
      step(0, 1, 8'd150);
      chk_pix("pend second", 2'd1, 1'd0);

      // Asynchronous reset mid-frame, away from any clock edge.
      #3 rst_n = 1'b0;
      #1;
      chk("async valid", valid_o, 0);
      chk("async x", x_o, 0);
      chk("async cnt", cnt_o, 0);
      chk("async tab", tab_o, 0);
      chk("async short", short_o, 0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 8'd150);
         chk($sformatf("post rst%0d valid", i), valid_o, 0);
         chk($sformatf("post rst%0d tab", i), tab_o, 0);
      end
      step(1, 0, 0);
      chk("post rst sof tab", tab_o, 0);
      chk("post rst sof cnt", cnt_o, 0);
      step(0, 1, 8'd150);
      chk_pix("post rst first", 2'd0, 1'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mask_coord_gen.md
# mask_coord_gen

Upstream feeder for `center_of_mass`: consumes the raw camera pixel stream, keeps x/y raster counters, thresholds each pixel against a programmable band, and emits one coordinate pulse per in-band pixel plus one `tabulate_out` pulse per frame. It guarantees that `valid_out` and `tabulate_out` never coincide, because `center_of_mass` lets tabulate win over a same-cycle valid. It also reports per-frame mask population and frame integrity.

## Interface
- `HRES`, 320, active pixels per line
- `VRES`, 180, active lines per frame
- `PIXEL_WIDTH`, 8, width of the thresholded pixel channel
- Derived widths: `HWIDTH = $clog2(HRES)`, `VWIDTH = $clog2(VRES)`, `CWIDTH = HWIDTH+VWIDTH`
- `clk_in`  in  1  system clock
- `rst_n_in`  in  1  asynchronous, active-low reset
- `pixel_in`  in  PIXEL_WIDTH  pixel value
- `pixel_valid_in`  in  1  pixel accepted this cycle
- `frame_start_in`  in  1  standalone start-of-frame pulse; never carries a pixel
- `lower_bound_in`  in  PIXEL_WIDTH  inclusive lower threshold
- `upper_bound_in`  in  PIXEL_WIDTH  inclusive upper threshold
- `x_out`  out  HWIDTH  column of the in-band pixel
- `y_out`  out  VWIDTH  row of the in-band pixel
- `valid_out`  out  1  one-cycle pulse; `x_out`/`y_out` are valid
- `tabulate_out`  out  1  one-cycle end-of-frame pulse
- `mask_count_out`  out  CWIDTH  in-band pixel count of the frame just closed; valid with `tabulate_out`
- `empty_out`  out  1  with `tabulate_out`: the closed frame had zero in-band pixels
- `short_frame_out`  out  1  with `tabulate_out`: the frame was aborted before pixel (HRES-1, VRES-1)

## Operation
- FSM states are `IDLE`, `ACTIVE` and `CLOSE`.
- `IDLE`:
  - Pixels are ignored.
  - `frame_start_in` clears x, y and the mask counter, then moves to `ACTIVE`.
- `ACTIVE`, on each `pixel_valid_in`:
  - Tag the pixel with the current (x, y).
  - Increment x. At x = HRES-1, wrap x to 0 and increment y.
  - A pixel is in band when `lower_bound_in <= pixel_in <= upper_bound_in`, unsigned and inclusive, using the bounds sampled in the same cycle. If lower > upper, no pixel is in band.
  - An in-band pixel increments the mask counter, saturating at 2^CWIDTH-1.
  - When pixel (HRES-1, VRES-1) is accepted, go to `CLOSE`.
- `CLOSE`:
  - Lasts exactly one cycle.
  - Goes to `IDLE`.
- `frame_start_in` in `ACTIVE` (mid-frame):
  - Closes the current frame as short: `tabulate_out` next cycle with `short_frame_out=1`.
  - Restarts counters at (0,0) and stays `ACTIVE`.
- `frame_start_in` in `CLOSE`:
  - Is registered and takes effect when `IDLE` is entered.
  - No extra tabulate is issued for it.
- A `frame_start_in` coinciding with `pixel_valid_in`:
  - Frame-start handling takes priority.
  - The pixel is dropped and counts toward nothing.
- `mask_count_out`, `empty_out` and `short_frame_out` are registered at tabulate and hold until the next tabulate.

## Timing
- Reset (async assert, sync deassert): `valid_out`, `tabulate_out`, `empty_out`, `short_frame_out` = 0; `x_out`, `y_out`, `mask_count_out` = 0; state = `IDLE`.
- Pixel accepted at cycle N → `valid_out` at N+1 if in band. `x_out`/`y_out` are registered and hold until the next `valid_out`.
- Final pixel accepted at N → its `valid_out` (if any) at N+1 → `tabulate_out` at N+2.
- Mid-frame `frame_start_in` at N → `tabulate_out` at N+1. A pixel at N+1 is (0,0) and produces `valid_out` at N+2.
- A pixel at N-1 gives its `valid_out` at N, and the tabulate at N+1 follows it. `valid_out` and `tabulate_out` are therefore never high together.
- Throughput is one pixel per cycle with no backpressure.
- Reset mid-frame discards the frame and emits no tabulate.

## Test plan
- HRES=4, VRES=2, bounds [100,200], sof then 8 pixels [50,100,150,250,200,0,199,201]:
  - `valid_out` coordinates are (1,0), (2,0), (0,1), (2,1).
  - `tabulate_out` occurs 2 cycles after the 8th pixel, with `mask_count_out`=4, `empty_out`=0, `short_frame_out`=0.
- Bounds lower=200, upper=100, full frame:
  - No `valid_out`.
  - `tabulate_out` with `mask_count_out`=0 and `empty_out`=1.
- Mid-frame `frame_start_in` after 3 pixels, all in band:
  - `tabulate_out` the next cycle with `short_frame_out`=1 and `mask_count_out`=3.
  - The next pixel reports (0,0).
- `frame_start_in` coincident with `pixel_valid_in`:
  - The pixel is dropped.
  - The following pixel reports (0,0).
- Gapped stream (pixels every third cycle) across a full frame:
  - Coordinates are identical to the back-to-back case.
  - Every `valid_out` is one cycle after its pixel.
- Assert `rst_n_in` mid-frame with no clock edge:
  - Outputs read 0 immediately.
  - Pixels after release are ignored until `frame_start_in`.
